// File: rtl/max7219_serial_rx.sv
// MAX7219-style 3-wire serial receiver (DIN/LOAD/CLK), oversampled in the i_clk domain.
// Decodes 16-bit frames into digit/control register images and forwards the cascade bit.
module max7219_serial_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          STRICT_LEN  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_serial_din,
    input  logic        i_serial_load,
    input  logic        i_serial_clk,
    output logic        o_serial_dout,
    output logic [63:0] o_digits,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_display_test,
    output logic        o_frame_stb,
    output logic [3:0]  o_frame_addr,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_err
);

    typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

    logic [SYNC_STAGES-1:0] din_sync_q, clk_sync_q, load_sync_q;
    logic                   clk_prev_q, load_prev_q;
    logic                   din_s, clk_s, load_s;
    logic                   clk_rise, clk_fall, load_rise;

    state_e      state_q;
    logic [15:0] shift_q, shift_next;
    logic [4:0]  cnt_q, cnt_next;
    logic        frame_ok;
    logic [2:0]  digit_idx;

    logic        dout_q, stb_q, err_q, shutdown_n_q, display_test_q;
    logic [3:0]  addr_q, intensity_q;
    logic [7:0]  data_q, decode_q;
    logic [2:0]  scan_q;
    logic [63:0] digits_q;

    // Synchronize the three serial inputs and keep one history flop for edge detection.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            din_sync_q  <= '0;
            clk_sync_q  <= '0;
            load_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            load_prev_q <= 1'b0;
        end else begin
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], i_serial_din};
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], i_serial_load};
            clk_prev_q  <= clk_s;
            load_prev_q <= load_s;
        end
    end

    // Edge detection and the post-shift view used by a coincident LOAD rise.
    always_comb begin
        din_s      = din_sync_q[SYNC_STAGES-1];
        clk_s      = clk_sync_q[SYNC_STAGES-1];
        load_s     = load_sync_q[SYNC_STAGES-1];
        clk_rise   = clk_s & ~clk_prev_q;
        clk_fall   = ~clk_s & clk_prev_q;
        load_rise  = load_s & ~load_prev_q;
        shift_next = shift_q;
        cnt_next   = cnt_q;
        if (clk_rise) begin
            shift_next = {shift_q[14:0], din_s};
            cnt_next   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end
        frame_ok  = STRICT_LEN ? (cnt_next == 5'd16) : (cnt_next >= 5'd16);
        // Address 1..8 maps to digit 0..7; 8 wraps to 7 in three bits.
        digit_idx = shift_next[10:8] - 3'd1;
    end

    // Frame FSM, shifter, cascade output and register file.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= StIdle;
            shift_q        <= '0;
            cnt_q          <= '0;
            dout_q         <= 1'b0;
            stb_q          <= 1'b0;
            err_q          <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            digits_q       <= '0;
            decode_q       <= '0;
            intensity_q    <= '0;
            scan_q         <= '0;
            shutdown_n_q   <= 1'b0;
            display_test_q <= 1'b0;
        end else begin
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            shift_q <= shift_next;
            if (clk_fall) begin
                dout_q <= shift_q[15];
            end
            if (load_rise) begin
                state_q <= StLatch;
                cnt_q   <= '0;
                if (frame_ok) begin
                    stb_q  <= 1'b1;
                    addr_q <= shift_next[11:8];
                    data_q <= shift_next[7:0];
                    case (shift_next[11:8])
                        4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8: digits_q[{digit_idx, 3'b000} +: 8] <= shift_next[7:0];
                        4'h9:    decode_q       <= shift_next[7:0];
                        4'hA:    intensity_q    <= shift_next[3:0];
                        4'hB:    scan_q         <= shift_next[2:0];
                        4'hC:    shutdown_n_q   <= shift_next[0];
                        4'hF:    display_test_q <= shift_next[0];
                        default: ;
                    endcase
                end else begin
                    err_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_next;
                case (state_q)
                    StIdle, StShift, StLatch: state_q <= (cnt_next != 5'd0) ? StShift : StIdle;
                    default:                  state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_serial_dout  = dout_q;
    assign o_digits       = digits_q;
    assign o_decode_mode  = decode_q;
    assign o_intensity    = intensity_q;
    assign o_scan_limit   = scan_q;
    assign o_shutdown_n   = shutdown_n_q;
    assign o_display_test = display_test_q;
    assign o_frame_stb    = stb_q;
    assign o_frame_addr   = addr_q;
    assign o_frame_data   = data_q;
    assign o_frame_err    = err_q;

endmodule
